// File: rtl/alu_arb_pkg.sv
// Shared types, command constants and flag layout for the ALU request arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    // Bit positions inside the 6-bit response flag word.
    localparam int unsigned FLG_COUT  = 0;
    localparam int unsigned FLG_OFLOW = 1;
    localparam int unsigned FLG_G     = 2;
    localparam int unsigned FLG_E     = 3;
    localparam int unsigned FLG_L     = 4;
    localparam int unsigned FLG_ERR   = 5;

    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Requester, ALU and response signals of the shared-ALU arbiter.
// slave is the arbiter's view; master is the requesters/ALU/consumer view.
interface alu_req_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_opa;
    logic [NREQ*W-1:0] req_opb;
    logic [NREQ*4-1:0] req_cmd;
    logic [NREQ-1:0]   req_mode;
    logic [NREQ-1:0]   req_cin;

    logic [W-1:0]      alu_opa;
    logic [W-1:0]      alu_opb;
    logic [3:0]        alu_cmd;
    logic              alu_mode;
    logic              alu_cin;
    logic              alu_ce;
    logic [1:0]        alu_inp_valid;
    logic [2*W-1:0]    alu_res;
    logic              alu_cout;
    logic              alu_oflow;
    logic              alu_g;
    logic              alu_e;
    logic              alu_l;
    logic              alu_err;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [2*W-1:0]    rsp_res;
    logic [5:0]        rsp_flags;

    modport slave (
        input  req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
        input  alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
        input  rsp_ready,
        output req_ready,
        output alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
        output rsp_valid, rsp_id, rsp_res, rsp_flags
    );

    modport master (
        output req_valid, req_opa, req_opb, req_cmd, req_mode, req_cin,
        output alu_res, alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err,
        output rsp_ready,
        input  req_ready,
        input  alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_ce, alu_inp_valid,
        input  rsp_valid, rsp_id, rsp_res, rsp_flags
    );

endinterface

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping;
// prio_en lets request 0 override the rotation.
module alu_rr_picker #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            prio_en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int unsigned   pos;
        logic [IW-1:0] pos_w;
        grant = '0;
        idx   = '0;
        pos   = 0;
        pos_w = '0;
        // Walk offsets from farthest to nearest so the nearest valid request wins.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            pos   = (32'(ptr) + 32'(k)) % NREQ;
            pos_w = IW'(pos);
            if (req[pos_w]) begin
                grant        = '0;
                grant[pos_w] = 1'b1;
                idx          = pos_w;
            end
        end
        if (prio_en && req[0]) begin
            grant    = '0;
            grant[0] = 1'b1;
            idx      = '0;
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant, issue, latency wait, tagged response.
// Build option: define ALU_ARB_PRIO_EN to make requester 0 high priority.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    alu_req_arbiter_if.slave bus
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef ALU_ARB_PRIO_EN
    localparam logic PRIO_EN = 1'b1;
`else
    localparam logic PRIO_EN = 1'b0;
`endif

    arb_state_t     state_q;
    logic [IW-1:0]  ptr_q, ptr_next, id_q;
    logic [7:0]     cnt_q;
    logic [W-1:0]   alu_opa_q, alu_opb_q;
    logic [3:0]     alu_cmd_q;
    logic           alu_mode_q, alu_cin_q, alu_ce_q;
    logic [1:0]     alu_inp_valid_q;
    logic           rsp_valid_q;
    logic [2*W-1:0] rsp_res_q;
    logic [5:0]     rsp_flags_q;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]  idx;

    alu_rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .prio_en (PRIO_EN),
        .grant   (grant),
        .idx     (idx)
    );

    // Ready is only offered in IDLE and is held off combinationally while reset is asserted.
    assign bus.req_ready = (state_q == IDLE && !rst) ? grant : '0;

    always_comb begin
        ptr_next = (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
        if (PRIO_EN && id_q == '0) begin
            ptr_next = ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            id_q            <= '0;
            cnt_q           <= '0;
            alu_opa_q       <= '0;
            alu_opb_q       <= '0;
            alu_cmd_q       <= '0;
            alu_mode_q      <= 1'b0;
            alu_cin_q       <= 1'b0;
            alu_ce_q        <= 1'b0;
            alu_inp_valid_q <= 2'b00;
            rsp_valid_q     <= 1'b0;
            rsp_res_q       <= '0;
            rsp_flags_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|grant) begin
                        alu_opa_q       <= bus.req_opa[idx*W +: W];
                        alu_opb_q       <= bus.req_opb[idx*W +: W];
                        alu_cmd_q       <= bus.req_cmd[idx*4 +: 4];
                        alu_mode_q      <= bus.req_mode[idx];
                        alu_cin_q       <= bus.req_cin[idx];
                        alu_ce_q        <= 1'b1;
                        alu_inp_valid_q <= 2'b11;
                        id_q            <= idx;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= is_mul(alu_mode_q, alu_cmd_q) ? 8'(MUL_LAT - 1) : 8'(ALU_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_res_q              <= bus.alu_res;
                        rsp_flags_q[FLG_COUT]  <= bus.alu_cout;
                        rsp_flags_q[FLG_OFLOW] <= bus.alu_oflow;
                        rsp_flags_q[FLG_G]     <= bus.alu_g;
                        rsp_flags_q[FLG_E]     <= bus.alu_e;
                        rsp_flags_q[FLG_L]     <= bus.alu_l;
                        rsp_flags_q[FLG_ERR]   <= bus.alu_err;
                        rsp_valid_q            <= 1'b1;
                        alu_ce_q               <= 1'b0;
                        alu_inp_valid_q        <= 2'b00;
                        state_q                <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_next;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_opa       = alu_opa_q;
    assign bus.alu_opb       = alu_opb_q;
    assign bus.alu_cmd       = alu_cmd_q;
    assign bus.alu_mode      = alu_mode_q;
    assign bus.alu_cin       = alu_cin_q;
    assign bus.alu_ce        = alu_ce_q;
    assign bus.alu_inp_valid = alu_inp_valid_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_res       = rsp_res_q;
    assign bus.rsp_flags     = rsp_flags_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a small combinational ALU stand-in.
module tb_alu_req_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_req_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    alu_req_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .ALU_LAT (1),
        .MUL_LAT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: ADD, CMP and MUL_INC in arithmetic mode; everything else reports ERR.
    always_comb begin
        bus.alu_res   = '0;
        bus.alu_cout  = 1'b0;
        bus.alu_oflow = 1'b0;
        bus.alu_g     = 1'b0;
        bus.alu_e     = 1'b0;
        bus.alu_l     = 1'b0;
        bus.alu_err   = 1'b0;
        if (bus.alu_mode) begin
            case (bus.alu_cmd)
                4'd0: {bus.alu_cout, bus.alu_res[W-1:0]} = 9'(bus.alu_opa) + 9'(bus.alu_opb);
                4'd8: begin
                    bus.alu_g = bus.alu_opa > bus.alu_opb;
                    bus.alu_e = bus.alu_opa == bus.alu_opb;
                    bus.alu_l = bus.alu_opa < bus.alu_opb;
                end
                4'd9: bus.alu_res = (16'(bus.alu_opa) + 16'd1) * (16'(bus.alu_opb) + 16'd1);
                default: bus.alu_err = 1'b1;
            endcase
        end else begin
            bus.alu_err = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call right after the accept edge; counts edges, accept edge included, until rsp_valid.
    task automatic wait_rsp(input int exp_edges, input string tag);
        int edges = 1;
        while (!bus.rsp_valid && edges < 10) begin
            tick();
            edges++;
        end
        check(tag, 32'(edges), 32'(exp_edges));
    endtask

    task automatic set_req(input logic [1:0] i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m, input logic ci);
        bus.req_opa[i*W +: W] = a;
        bus.req_opb[i*W +: W] = b;
        bus.req_cmd[i*4 +: 4] = c;
        bus.req_mode[i]       = m;
        bus.req_cin[i]        = ci;
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  exp_id  [5];
        logic [15:0] exp_res [5];
        logic [5:0]  exp_flg [5];

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        bus.req_cmd   = '0;
        bus.req_mode  = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_alu_ce", 32'(bus.alu_ce), 32'h0);
        check("rst_alu_inp_valid", 32'(bus.alu_inp_valid), 32'h0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_flags}), 32'h0);
        check("rst_alu_ops", 32'({bus.alu_opa, bus.alu_opb, bus.alu_cmd}), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Single ADD from requester 1.
        set_req(2'd1, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0);
        bus.req_valid = 4'b0010;
        #1;
        check("t1_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        check("t1_issue_ready", 32'(bus.req_ready), 32'h0);
        check("t1_issue_ce_iv", 32'({bus.alu_ce, bus.alu_inp_valid}), 32'h7);
        check("t1_issue_ops", 32'({bus.alu_opa, bus.alu_opb, bus.alu_cmd, bus.alu_mode}),
              32'({8'h0F, 8'h01, 4'd0, 1'b1}));
        wait_rsp(3, "t1_latency");
        check("t1_rsp_id", 32'(bus.rsp_id), 32'h1);
        check("t1_rsp_res", 32'(bus.rsp_res), 32'h0010);
        check("t1_rsp_flags", 32'(bus.rsp_flags), 32'h0);
        check("t1_resp_ce_iv", 32'({bus.alu_ce, bus.alu_inp_valid}), 32'h0);
        check("t1_resp_opa_hold", 32'(bus.alu_opa), 32'h0F);
        release_rsp();
        check("t1_rsp_drop", 32'(bus.rsp_valid), 32'h0);

        // Backpressure: pointer is 2, requesters 1 and 2 valid, response held for 5 cycles.
        set_req(2'd2, 8'h20, 8'h05, 4'd0, 1'b1, 1'b0);
        set_req(2'd1, 8'h01, 8'h02, 4'd0, 1'b1, 1'b0);
        bus.req_valid = 4'b0110;
        #1;
        check("t4_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0010;
        wait_rsp(3, "t4_latency");
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_stall_hold", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.req_ready}),
                  32'({1'b1, 2'd2, 16'h0025, 4'b0000}));
        end
        release_rsp();

        // Pointer now 3; requester 0 wins by wrapping ahead of requester 1. Multiply latency.
        set_req(2'd0, 8'd3, 8'd4, 4'd9, 1'b1, 1'b0);
        bus.req_valid = 4'b0011;
        #1;
        check("t3_wrap_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        wait_rsp(4, "t3_mul_latency");
        check("t3_mul_res", 32'(bus.rsp_res), 32'd20);
        check("t3_mul_id", 32'(bus.rsp_id), 32'h0);
        release_rsp();

        // Invalid command completes with ERR set.
        set_req(2'd1, 8'h11, 8'h22, 4'd15, 1'b1, 1'b1);
        bus.req_valid = 4'b0010;
        #1;
        check("t_err_grant", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        wait_rsp(3, "t_err_latency");
        check("t_err_flags", 32'({bus.rsp_id, bus.rsp_flags}), 32'({2'd1, 6'b100000}));
        release_rsp();

        // Compare: L flag lands in bit 4.
        set_req(2'd2, 8'd5, 8'd9, 4'd8, 1'b1, 1'b0);
        bus.req_valid = 4'b0100;
        #1;
        tick();
        bus.req_valid = '0;
        wait_rsp(3, "t_cmp_latency");
        check("t_cmp_flags", 32'({bus.rsp_id, bus.rsp_flags}), 32'({2'd2, 6'b010000}));
        release_rsp();

        // Reset during WAIT: everything clears without a clock edge; pointer back to 0.
        set_req(2'd3, 8'h40, 8'h02, 4'd0, 1'b1, 1'b0);
        bus.req_valid = 4'b1000;
        #1;
        check("t5_grant", 32'(bus.req_ready), 32'h8);
        tick();
        tick();
        #2;
        rst           = 1'b1;
        bus.req_valid = 4'b1001;
        #1;
        check("t5_async_ce_iv", 32'({bus.alu_ce, bus.alu_inp_valid}), 32'h0);
        check("t5_async_alu_ops", 32'({bus.alu_opa, bus.alu_opb}), 32'h0);
        check("t5_async_rsp", 32'({bus.rsp_valid, bus.rsp_res}), 32'h0);
        check("t5_async_ready", 32'(bus.req_ready), 32'h0);
        tick();
        tick();
        check("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
        rst = 1'b0;
        #1;
        check("t5_post_grant", 32'(bus.req_ready), 32'h1);

`ifdef ALU_ARB_PRIO_EN
        // Move pointer to 2, then requester 0 must win every time while valid.
        set_req(2'd0, 8'h11, 8'h01, 4'd0, 1'b1, 1'b0);
        set_req(2'd1, 8'h22, 8'h02, 4'd0, 1'b1, 1'b0);
        set_req(2'd2, 8'h33, 8'h03, 4'd0, 1'b1, 1'b0);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b1;
        #1;
        tick();
        bus.req_valid = '0;
        wait_rsp(3, "t6_setup_latency");
        tick();
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.req_valid = 4'b0100;
            #1;
            check("t6_grant", 32'(bus.req_ready), (k == 3) ? 32'h4 : 32'h1);
            tick();
            wait_rsp(3, "t6_latency");
            check("t6_rsp_id", 32'(bus.rsp_id), (k == 3) ? 32'h2 : 32'h0);
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
`else
        // All four valid continuously with the consumer always ready: 0,1,2,3,0.
        set_req(2'd0, 8'h11, 8'h01, 4'd0, 1'b1, 1'b0);
        set_req(2'd1, 8'h22, 8'h02, 4'd0, 1'b1, 1'b0);
        set_req(2'd2, 8'h33, 8'h03, 4'd0, 1'b1, 1'b0);
        set_req(2'd3, 8'h80, 8'h90, 4'd0, 1'b1, 1'b0);
        exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_res = '{16'h0012, 16'h0024, 16'h0036, 16'h0010, 16'h0012};
        exp_flg = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h00};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t2_grant", 32'(bus.req_ready), 32'(4'b0001 << exp_id[k]));
            tick();
            wait_rsp(3, "t2_latency");
            check("t2_rsp_id", 32'(bus.rsp_id), 32'(exp_id[k]));
            check("t2_rsp", 32'({bus.rsp_res, bus.rsp_flags}), 32'({exp_res[k], exp_flg[k]}));
            tick();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one alu_design instance among NREQ independent requesters. Each requester hands over a complete ALU operation (operands, CMD, MODE, CIN) through a valid/ready handshake. The block grants requests round-robin, sequences the operation through the ALU with command-dependent latency, and returns RES plus flags tagged with the requester ID. It sits between the requester clients and the ALU input/output ports, one operation in flight at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width (matches ALU OPA/OPB)
ALU_LAT, 1, WAIT cycles for non-multiply commands
MUL_LAT, 2, WAIT cycles for multiply commands (MODE=1, CMD=9 or CMD=10)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
REQ_VALID  in  NREQ  per-requester operation valid
REQ_READY  out  NREQ  per-requester accept, one-hot or zero
REQ_OPA  in  NREQ*W  flattened operand A, requester i at [i*W +: W]
REQ_OPB  in  NREQ*W  flattened operand B
REQ_CMD  in  NREQ*4  flattened command
REQ_MODE  in  NREQ  1=arithmetic, 0=logical
REQ_CIN  in  NREQ  carry-in
ALU_OPA / ALU_OPB  out  W  to ALU
ALU_CMD  out  4;  ALU_MODE, ALU_CIN, ALU_CE  out  1;  ALU_INP_VALID  out  2
ALU_RES  in  2*W;  ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR  in  1 each
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed
RSP_ID  out  clog2(NREQ)  requester that owns the response
RSP_RES  out  2*W  captured result
RSP_FLAGS  out  6  {ERR,L,E,G,OFLOW,COUT}

Behaviour:
- Clock CLK. RST asynchronous and active-high: all state clears immediately; no synchronous reset path.
- Reset values: state=IDLE, rr pointer=0, REQ_READY=0, all ALU_* outputs=0 (CE=0, INP_VALID=2'b00), RSP_VALID=0, RSP_ID/RES/FLAGS=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - REQ_READY is combinational. One-hot for the first asserted REQ_VALID at or after the rr pointer, wrapping modulo NREQ.
  - On handshake (valid&ready), latch that requester's fields and ID, then go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE (1 cycle):
  - Drive latched fields onto ALU_*, with ALU_INP_VALID=2'b11 and ALU_CE=1.
  - Load the WAIT counter with LAT-1, where LAT=MUL_LAT if MODE=1 and CMD is 9 or 10, else ALU_LAT.
  - Go to WAIT.
- WAIT:
  - ALU_* stays stable and CE=1.
  - Counter decrements each cycle. At count 0, capture ALU_RES and flags into RSP_*, assert RSP_VALID, and go to RESP.
- RESP:
  - ALU_CE=0 and ALU_INP_VALID=2'b00. Operand outputs hold their last value.
  - RSP_* held stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_READY=1: RSP_VALID drops the next cycle, rr pointer = winner+1 (mod NREQ), go to IDLE.
  - The next request is accepted no earlier than the cycle after RESP exits (no overlap).
- Latency: accept edge to RSP_VALID high = LAT+2 edges. ALU_LAT=1 gives 3; multiply gives 4.
- REQ_READY is 0 in every state except IDLE. A requester deasserting REQ_VALID before handshake is legal and loses nothing.
- Wrap: pointer at NREQ-1 with only requester 0 valid grants requester 0.
- ALU_ERR is passed through unmodified. Invalid commands complete normally with FLAGS[5]=1.
- RST asserted mid-operation: in-flight operation and any pending response are discarded, no RSP_VALID is produced, pointer returns to 0.

Optional Feature:
ALU_ARB_PRIO_EN
- Defined: requester 0 is high priority. If REQ_VALID[0]=1 in IDLE it is granted regardless of the pointer, and the pointer is not updated on a requester-0 grant.
- Undefined: pure round-robin as above.

Decomposition:
- Package alu_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t
  - constants CMD_MUL_INC=4'd9, CMD_MUL_SHL=4'd10
  - flag bit indices FLG_COUT..FLG_ERR
  - function is_mul(mode, cmd)
- Sub-module alu_rr_picker(NREQ): inputs req vector, pointer, and prio-enable; outputs one-hot grant and encoded index. Purely combinational.

Test Plan:
1. Single request: req1 OPA=8'h0F, OPB=8'h01, CMD=0 (ADD), MODE=1, CIN=0 -> REQ_READY[1] at the accept edge, RSP_VALID 3 edges later, RSP_ID=1, RSP_RES=16'h0010, FLAGS=0.
2. All 4 requesters valid continuously, RSP_READY=1 -> grant order 0,1,2,3,0; each response ID matches its grant.
3. Multiply: MODE=1, CMD=9, OPA=3, OPB=4 -> RSP_VALID 4 edges after accept, RSP_RES=(3+1)*(4+1)=20.
4. Backpressure: RSP_READY=0 for 5 cycles -> RSP_* stable, REQ_READY=0 throughout, next grant only after the RSP_READY handshake.
5. RST asserted during WAIT -> all outputs return to reset values without waiting for a clock edge; no response emitted; first post-reset grant goes to requester 0.
6. With ALU_ARB_PRIO_EN defined, requesters 0 and 2 valid continuously, pointer=2 -> requester 0 is granted every time; requester 2 is granted only when REQ_VALID[0]=0.
